keccak_absorb_ctrl: RTL and testbench

Sequencing controller for the Keccak sponge absorb phase. It accepts a 256-bit keep-qualified message stream and drives one instance of `keccak_absorb_unit` beat by beat. It handles block-boundary carry-over, issues Keccak-f permutation requests, and applies the domain-suffix / pad10*1 padding. It sits between the core's input stream and the state register / permutation engine, and signals when squeezing may begin.

---
 rtl/keccak_pkg.sv | 32 +++
 rtl/keccak_absorb_unit.sv | 42 ++++
 rtl/keccak_absorb_ctrl.sv | 145 ++++++++++++++
 tb/tb_keccak_absorb_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared widths, absorb FSM encoding and small helpers for the Keccak sponge datapath.
package keccak_pkg;
    localparam int DWIDTH            = 256;
    localparam int KEEP_WIDTH        = 32;
    localparam int LANE_SIZE         = 64;
    localparam int ROW_SIZE          = 5;
    localparam int COL_SIZE          = 5;
    localparam int STATE_WIDTH       = ROW_SIZE * COL_SIZE * LANE_SIZE;
    localparam int STATE_BYTES       = STATE_WIDTH / 8;
    localparam int RATE_WIDTH        = 11;
    localparam int BYTE_ABSORB_WIDTH = 8;

    localparam logic [7:0] PAD_END_BYTE = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PERMUTE,
        CARRY,
        PAD_SUFFIX,
        PAD_END,
        FINAL_PERM,
        DONE
    } absorb_state_e;

    function automatic logic [5:0] popcount(input logic [KEEP_WIDTH-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) n = n + 6'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/keccak_absorb_unit.sv
// XORs one keep-qualified beat into the state at byte offset cnt; bytes falling
// past the rate are returned, shifted down to byte 0, as carry for the next block.
module keccak_absorb_unit
    import keccak_pkg::*;
(
    input  logic [STATE_WIDTH-1:0]       state,
    input  logic [DWIDTH-1:0]            msg,
    input  logic [KEEP_WIDTH-1:0]        keep,
    input  logic [BYTE_ABSORB_WIDTH-1:0] cnt,
    input  logic [BYTE_ABSORB_WIDTH-1:0] rate_bytes,
    output logic [STATE_WIDTH-1:0]       absorbed,
    output logic [BYTE_ABSORB_WIDTH-1:0] new_cnt,
    output logic                         carry,
    output logic [DWIDTH-1:0]            carry_data,
    output logic [KEEP_WIDTH-1:0]        carry_keep
);
    localparam int WIDE_BYTES = STATE_BYTES + KEEP_WIDTH;

    logic [DWIDTH-1:0]       masked;
    logic [8*WIDE_BYTES-1:0] data_w;
    logic [WIDE_BYTES-1:0]   keep_w;

    always_comb begin
        masked = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (keep[i]) masked[8*i +: 8] = msg[8*i +: 8];
        end
        data_w = {{(8*STATE_BYTES){1'b0}}, masked} << {cnt, 3'b000};
        keep_w = {{STATE_BYTES{1'b0}}, keep} << cnt;

        absorbed = state;
        for (int k = 0; k < STATE_BYTES; k++) begin
            if (keep_w[k] && (k < 32'(rate_bytes))) absorbed[8*k +: 8] ^= data_w[8*k +: 8];
        end

        // Everything at or beyond the rate boundary becomes carry, realigned to byte 0.
        carry_data = DWIDTH'(data_w >> {rate_bytes, 3'b000});
        carry_keep = KEEP_WIDTH'(keep_w >> rate_bytes);
        carry      = |carry_keep;
        new_cnt    = carry ? rate_bytes : cnt + BYTE_ABSORB_WIDTH'(popcount(keep));
    end
endmodule

// File: rtl/keccak_absorb_ctrl.sv
// Absorb-phase sequencer: feeds stream beats, carry-over and padding bytes into
// the absorb unit and requests Keccak-f permutations at block boundaries.
module keccak_absorb_ctrl
    import keccak_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [RATE_WIDTH-1:0]  rate_i,
    input  logic [7:0]             suffix_i,
    input  logic                   t_valid_i,
    output logic                   t_ready_o,
    input  logic [DWIDTH-1:0]      t_data_i,
    input  logic [KEEP_WIDTH-1:0]  t_keep_i,
    input  logic                   t_last_i,
    input  logic [STATE_WIDTH-1:0] state_i,
    output logic [STATE_WIDTH-1:0] state_o,
    output logic                   state_we_o,
    output logic                   state_clear_o,
    output logic                   perm_start_o,
    input  logic                   perm_done_i,
    output logic                   absorb_done_o,
    output logic                   busy_o
);
    absorb_state_e                fsm, ret_q;
    logic [BYTE_ABSORB_WIDTH-1:0] cnt_q;
    logic [RATE_WIDTH-1:0]        rate_q;
    logic [7:0]                   suffix_q;
    logic [DWIDTH-1:0]            carry_q;
    logic [KEEP_WIDTH-1:0]        carry_keep_q;
    logic                         carry_last_q;
    logic                         perm_issued_q;

    logic [BYTE_ABSORB_WIDTH-1:0] rate_bytes;
    logic [DWIDTH-1:0]            u_msg, u_carry_data;
    logic [KEEP_WIDTH-1:0]        u_keep, u_carry_keep;
    logic [BYTE_ABSORB_WIDTH-1:0] u_cnt, u_new_cnt;
    logic                         u_carry;
    logic                         handshake;

    assign rate_bytes = BYTE_ABSORB_WIDTH'(rate_q >> 3);
    assign handshake  = (fsm == ABSORB) && t_valid_i;

    always_comb begin
        u_msg  = t_data_i;
        u_keep = '0;
        u_cnt  = cnt_q;
        unique case (fsm)
            ABSORB:     if (t_valid_i) u_keep = t_keep_i;
            CARRY: begin
                u_msg  = carry_q;
                u_keep = carry_keep_q;
                u_cnt  = '0;
            end
            // Suffix goes to the byte right after the message, addressed as an 8-byte lane.
            PAD_SUFFIX: begin
                u_msg  = DWIDTH'(suffix_q) << {cnt_q[2:0], 3'b000};
                u_keep = KEEP_WIDTH'(1) << cnt_q[2:0];
                u_cnt  = cnt_q & 8'hF8;
            end
            PAD_END: begin
                u_msg  = DWIDTH'(PAD_END_BYTE) << 56;
                u_keep = KEEP_WIDTH'(8'h80);
                u_cnt  = rate_bytes - 8'd8;
            end
            default: ;
        endcase
    end

    keccak_absorb_unit u_unit (
        .state      (state_i),
        .msg        (u_msg),
        .keep       (u_keep),
        .cnt        (u_cnt),
        .rate_bytes (rate_bytes),
        .absorbed   (state_o),
        .new_cnt    (u_new_cnt),
        .carry      (u_carry),
        .carry_data (u_carry_data),
        .carry_keep (u_carry_keep)
    );

    assign t_ready_o     = (fsm == ABSORB);
    assign state_we_o    = handshake || (fsm inside {CARRY, PAD_SUFFIX, PAD_END});
    assign state_clear_o = (fsm == IDLE) && start_i;
    assign perm_start_o  = (fsm inside {PERMUTE, FINAL_PERM}) && !perm_issued_q;
    assign absorb_done_o = (fsm == DONE);
    assign busy_o        = (fsm != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm           <= IDLE;
            ret_q         <= IDLE;
            cnt_q         <= '0;
            rate_q        <= '0;
            suffix_q      <= '0;
            carry_q       <= '0;
            carry_keep_q  <= '0;
            carry_last_q  <= 1'b0;
            perm_issued_q <= 1'b0;
        end else begin
            unique case (fsm)
                IDLE: if (start_i) begin
                    cnt_q    <= '0;
                    rate_q   <= rate_i;
                    suffix_q <= suffix_i;
                    fsm      <= ABSORB;
                end
                ABSORB: if (t_valid_i) begin
                    if (u_carry) begin
                        carry_q      <= u_carry_data;
                        carry_keep_q <= u_carry_keep;
                        carry_last_q <= t_last_i;
                        cnt_q        <= '0;
                        ret_q        <= CARRY;
                        fsm          <= PERMUTE;
                    end else if (u_new_cnt == rate_bytes) begin
                        cnt_q <= '0;
                        ret_q <= t_last_i ? PAD_SUFFIX : ABSORB;
                        fsm   <= PERMUTE;
                    end else begin
                        cnt_q <= u_new_cnt;
                        fsm   <= t_last_i ? PAD_SUFFIX : ABSORB;
                    end
                end
                // A done seen in the request cycle belongs to no request of ours.
                PERMUTE, FINAL_PERM: begin
                    perm_issued_q <= 1'b1;
                    if (perm_done_i && perm_issued_q) begin
                        perm_issued_q <= 1'b0;
                        fsm           <= (fsm == PERMUTE) ? ret_q : DONE;
                    end
                end
                CARRY: begin
                    cnt_q <= u_new_cnt;
                    fsm   <= carry_last_q ? PAD_SUFFIX : ABSORB;
                end
                PAD_SUFFIX: fsm <= PAD_END;
                PAD_END:    fsm <= FINAL_PERM;
                DONE:       fsm <= IDLE;
                default:    fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Bench for keccak_absorb_ctrl: state register and permutation responder models,
// byte-level sponge reference model feeding an expected queue checked on absorb_done_o.
module tb_keccak_absorb_ctrl;
    import keccak_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start_i = 1'b0;
    logic [RATE_WIDTH-1:0]  rate_i = '0;
    logic [7:0]             suffix_i = '0;
    logic                   t_valid_i = 1'b0;
    logic                   t_ready_o;
    logic [DWIDTH-1:0]      t_data_i = '0;
    logic [KEEP_WIDTH-1:0]  t_keep_i = '0;
    logic                   t_last_i = 1'b0;
    logic [STATE_WIDTH-1:0] st;
    logic [STATE_WIDTH-1:0] state_o;
    logic                   state_we_o, state_clear_o, perm_start_o, absorb_done_o, busy_o;
    logic                   perm_done_i = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int perm_lat = 4;
    int rem = 0;
    int perm_cnt = 0;
    int ready_viol = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int hs_cyc = 0;
    bit early_done = 0;
    bit stray_done = 0;
    bit perm_real = 0;

    logic [STATE_WIDTH-1:0] exp_q[$];
    int                     exp_perm_q[$];
    logic [7:0]             msg_b [0:511];

    keccak_absorb_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .rate_i        (rate_i),
        .suffix_i      (suffix_i),
        .t_valid_i     (t_valid_i),
        .t_ready_o     (t_ready_o),
        .t_data_i      (t_data_i),
        .t_keep_i      (t_keep_i),
        .t_last_i      (t_last_i),
        .state_i       (st),
        .state_o       (state_o),
        .state_we_o    (state_we_o),
        .state_clear_o (state_clear_o),
        .perm_start_o  (perm_start_o),
        .perm_done_i   (perm_done_i),
        .absorb_done_o (absorb_done_o),
        .busy_o        (busy_o)
    );

    // Clock / reset-related bench state
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // State register; the stand-in permutation inverts every bit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       st <= '0;
        else if (state_clear_o)           st <= '0;
        else if (state_we_o)              st <= state_o;
        else if (perm_done_i && perm_real) st <= ~st;
    end

    // Permutation responder: done is sampled in the P-th cycle counted from the request.
    initial begin
        forever begin
            @(negedge clk);
            perm_done_i = 1'b0;
            perm_real   = 1'b0;
            if (!rst_n) begin
                rem = 0;
            end else begin
                if ((rem > 0 || perm_start_o) && t_ready_o) ready_viol++;
                if (perm_start_o) perm_cnt++;
                if (rem > 0) begin
                    rem--;
                    if (rem == 0) begin
                        perm_done_i = 1'b1;
                        perm_real   = 1'b1;
                    end
                end else if (perm_start_o) begin
                    rem = perm_lat - 1;
                    if (early_done) perm_done_i = 1'b1;
                end else if (stray_done) begin
                    perm_done_i = 1'b1;
                end
            end
        end
    end

    // Scoreboard: pop one expectation per absorb_done_o pulse.
    initial begin
        logic [STATE_WIDTH-1:0] e;
        int ep;
        int fb;
        forever begin
            @(negedge clk);
            if (rst_n && absorb_done_o) begin
                done_cnt++;
                done_cyc = cyc;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: got absorb_done_o=1 required no pulse (queue empty)");
                end else begin
                    e  = exp_q.pop_front();
                    ep = exp_perm_q.pop_front();
                    if (st !== e) begin
                        fails++;
                        fb = 0;
                        for (int i = STATE_BYTES - 1; i >= 0; i--)
                            if (st[8*i +: 8] !== e[8*i +: 8]) fb = i;
                        $display("FAIL final_state: byte %0d got %02h required %02h", fb, st[8*fb +: 8], e[8*fb +: 8]);
                    end
                    tests++;
                    if (perm_cnt !== ep) begin
                        fails++;
                        $display("FAIL perm_count: got %0d required %0d", perm_cnt, ep);
                    end
                end
            end
        end
    end

    // Reference sponge: pad10*1 with domain suffix, XOR each block, then permute.
    function automatic void model(input int rb, input logic [7:0] sfx, input int len,
                                  output logic [STATE_WIDTH-1:0] s, output int np);
        logic [7:0] pb [0:767];
        int total;
        total = (len / rb + 1) * rb;
        np    = total / rb;
        for (int i = 0; i < total; i++) pb[i] = (i < len) ? msg_b[i] : 8'h00;
        pb[len]       = pb[len] ^ sfx;
        pb[total - 1] = pb[total - 1] ^ 8'h80;
        s = '0;
        for (int blk = 0; blk < np; blk++) begin
            for (int i = 0; i < rb; i++) s[8*i +: 8] = s[8*i +: 8] ^ pb[blk*rb + i];
            s = ~s;
        end
    endfunction

    // Driver: start pulse, then beats with t_valid_i held high until the final handshake.
    task automatic drive_msg(input int rate, input logic [7:0] sfx, input int len,
                             input bit last_msg, input bit spurious);
        logic [STATE_WIDTH-1:0] e;
        logic [DWIDTH-1:0]      d;
        logic [KEEP_WIDTH-1:0]  k;
        int np, nb, budget, idx;
        if (last_msg) begin
            model(rate / 8, sfx, len, e, np);
            exp_q.push_back(e);
            exp_perm_q.push_back(np);
        end
        budget = 0;
        while (busy_o && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        perm_cnt = 0;
        start_i  = 1'b1;
        rate_i   = RATE_WIDTH'(rate);
        suffix_i = sfx;
        @(negedge clk);
        start_i = 1'b0;
        nb = (len == 0) ? 1 : (len + 31) / 32;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 32; j++) begin
                idx = b * 32 + j;
                if (idx < len) begin
                    d[8*j +: 8] = msg_b[idx];
                    k[j]        = 1'b1;
                end
            end
            t_valid_i = 1'b1;
            t_data_i  = d;
            t_keep_i  = k;
            t_last_i  = last_msg && (b == nb - 1);
            if (spurious && b == 1) start_i = 1'b1;
            budget = 0;
            while (!t_ready_o && budget < 2000) begin
                @(negedge clk);
                start_i = 1'b0;
                budget++;
            end
            if (!t_ready_o) begin
                tests++;
                fails++;
                $display("FAIL handshake_timeout: beat %0d got t_ready_o=0 required 1 within 2000 cycles", b);
                t_valid_i = 1'b0;
                t_last_i  = 1'b0;
                return;
            end
            hs_cyc = cyc;
            @(negedge clk);
            start_i = 1'b0;
        end
        t_valid_i = 1'b0;
        t_last_i  = 1'b0;
        t_keep_i  = '0;
    endtask

    task automatic wait_done(input int prev, input string name);
        int budget;
        budget = 0;
        while (done_cnt == prev && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        tests++;
        if (done_cnt == prev) begin
            fails++;
            $display("FAIL %s_done_timeout: got no absorb_done_o required one pulse", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({t_ready_o, state_we_o, state_clear_o, perm_start_o, absorb_done_o, busy_o} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %06b required 000000",
                     {t_ready_o, state_we_o, state_clear_o, perm_start_o, absorb_done_o, busy_o});
        end
        tests++;
        if (state_o !== '0) begin
            fails++;
            $display("FAIL reset_state_o: got nonzero required 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sha3_single();
        int prev;
        prev     = done_cnt;
        perm_lat = 5;
        drive_msg(1088, 8'h06, 32, 1, 0);
        wait_done(prev, "sha3_single");
        tests++;
        if (done_cyc - hs_cyc !== 3 + perm_lat) begin
            fails++;
            $display("FAIL done_latency: got %0d required %0d", done_cyc - hs_cyc, 3 + perm_lat);
        end
    endtask

    task automatic test_block_boundary();
        int prev;
        prev = done_cnt;
        drive_msg(1088, 8'h06, 136, 1, 0);
        wait_done(prev, "block_boundary");
    endtask

    task automatic test_carry();
        int prev;
        prev = done_cnt;
        drive_msg(1088, 8'h06, 160, 1, 1);
        wait_done(prev, "carry");
    endtask

    task automatic test_shake_empty();
        int prev;
        prev = done_cnt;
        drive_msg(1344, 8'h1F, 0, 1, 0);
        wait_done(prev, "shake_empty");
    endtask

    task automatic test_pad_collision();
        int prev;
        prev = done_cnt;
        drive_msg(576, 8'h06, 71, 1, 0);
        wait_done(prev, "pad_collision");
        prev = done_cnt;
        drive_msg(576, 8'h06, 72, 1, 0);
        wait_done(prev, "full_block_576");
    endtask

    task automatic test_ready_during_perm();
        int prev;
        prev       = done_cnt;
        perm_lat   = 24;
        ready_viol = 0;
        drive_msg(1088, 8'h06, 300, 1, 0);
        wait_done(prev, "ready_perm");
        tests++;
        if (ready_viol !== 0) begin
            fails++;
            $display("FAIL ready_during_perm: got %0d cycles with t_ready_o=1 required 0", ready_viol);
        end
        perm_lat = 4;
    endtask

    task automatic test_ignored_done();
        int prev;
        prev       = done_cnt;
        perm_lat   = 6;
        early_done = 1;
        stray_done = 1;
        drive_msg(832, 8'h1F, 200, 1, 0);
        wait_done(prev, "ignored_done");
        early_done = 0;
        stray_done = 0;
        perm_lat   = 4;
    endtask

    task automatic test_back_to_back();
        int rates [5] = '{576, 832, 1088, 1152, 1344};
        int prev;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 512; i++) msg_b[i] = 8'($urandom);
            perm_lat = $urandom_range(2, 10);
            prev     = done_cnt;
            drive_msg(rates[$urandom_range(0, 4)], ($urandom_range(0, 1) == 1) ? 8'h06 : 8'h1F,
                      $urandom_range(0, 300), 1, 0);
            wait_done(prev, "back_to_back");
        end
        perm_lat = 4;
    endtask

    task automatic test_reset_mid_perm();
        int prev;
        prev     = done_cnt;
        perm_lat = 20;
        drive_msg(576, 8'h06, 96, 0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({t_ready_o, state_we_o, state_clear_o, perm_start_o, absorb_done_o, busy_o} !== 6'b0) begin
            fails++;
            $display("FAIL mid_perm_reset_outputs: got %06b required 000000",
                     {t_ready_o, state_we_o, state_clear_o, perm_start_o, absorb_done_o, busy_o});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        tests++;
        if (done_cnt !== prev || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_perm_abort: got done_cnt=%0d busy=%0b required done_cnt=%0d busy=0",
                     done_cnt, busy_o, prev);
        end
        perm_lat = 4;
        drive_msg(1088, 8'h06, 40, 1, 0);
        wait_done(prev, "post_reset");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) msg_b[i] = 8'($urandom);
        test_reset();
        test_sha3_single();
        test_block_boundary();
        test_carry();
        test_shake_empty();
        test_pad_collision();
        test_ready_during_perm();
        test_ignored_done();
        test_back_to_back();
        test_reset_mid_perm();
        repeat (5) @(negedge clk);
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL leftover_expected: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
